key_expansion_ctrl: RTL and testbench

AES-128 key-schedule sequencer. It captures a 128-bit cipher key and drives the existing multi-cycle `G` block (RotWord/SubWord/Rcon on one word) once per round. It XOR-chains each `G` result into the next round key and hands round keys 0..10 to the cipher datapath over a valid/ready stream. It sits between the host key-load interface and the round-key consumer, and is the only master of its `G` instance.

---
 rtl/key_expansion_ctrl.sv | 146 ++++++++++++++
 tb/tb_key_expansion_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: AES-128 key-schedule sequencer driving an external G block.
// Define KEY_STORE_EN to build the 11-entry round-key store behind rk_rd_idx/rk_rd_data.
`timescale 1ns/1ps
module key_expansion_ctrl #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         g_enable,
  output logic [31:0]  g_input,
  output logic [3:0]   g_round,
  input  logic [31:0]  g_output,
  input  logic         g_done,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    G_REQ,
    G_WAIT
  } state_t;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;

  assign rk_data = {w0, w1, w2, w3};

  // Each new word chains off the one just produced
  assign n0 = w0 ^ g_output;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      g_enable <= 1'b0;
      g_input  <= '0;
      g_round  <= '0;
    end else begin
      done     <= 1'b0;
      g_enable <= 1'b0;
      if (state != IDLE && abort) begin
        state    <= IDLE;
        rk_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              {w0, w1, w2, w3} <= key_in;
              rk_idx   <= '0;
              rk_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= OUT;
            end
          end
          OUT: begin
            if (rk_ready) begin
              rk_valid <= 1'b0;
              if (rk_idx == LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                g_enable <= 1'b1;
                g_input  <= w3;
                g_round  <= rk_idx + 4'd1;
                state    <= G_REQ;
              end
            end
          end
          G_REQ: begin
            state <= G_WAIT;
          end
          G_WAIT: begin
            if (g_done) begin
              w0       <= n0;
              w1       <= n1;
              w2       <= n2;
              w3       <= n3;
              rk_idx   <= rk_idx + 4'd1;
              rk_valid <= 1'b1;
              state    <= OUT;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef KEY_STORE_EN
  logic [127:0] store [0:10];
  logic         ld_key;
  logic         ld_g;
  logic [3:0]   wr_idx;

  // Written on the same edges that move the FSM into OUT
  assign ld_key = (state == IDLE) && start;
  assign ld_g   = (state == G_WAIT) && !abort && g_done;
  assign wr_idx = rk_idx + 4'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= 10; i++) store[i] <= '0;
    end else if (ld_key) begin
      store[0] <= key_in;
    end else if (ld_g && wr_idx <= 4'd10) begin
      store[wr_idx] <= {n0, n1, n2, n3};
    end
  end

  assign rk_rd_data = (rk_rd_idx <= 4'd10) ? store[rk_rd_idx] : '0;
`else
  logic unused_rd;

  assign unused_rd  = ^rk_rd_idx;
  assign rk_rd_data = '0;
`endif

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb_key_expansion_ctrl: randomized run of the key sequencer against a
// behavioural AES-128 key schedule, with the G block modelled in the bench.
`timescale 1ns/1ps
module tb_key_expansion_ctrl;

  logic         tb_clk   = 1'b0;
  logic         n_rst    = 1'b0;
  logic         start    = 1'b0;
  logic [127:0] key_in   = '0;
  logic         abort    = 1'b0;
  logic         rk_ready = 1'b0;
  logic [31:0]  g_output = '0;
  logic         g_done   = 1'b0;
  logic [3:0]   rk_rd_idx = 4'd1;
  logic         busy, done, rk_valid, g_enable;
  logic [127:0] rk_data, rk_rd_data;
  logic [3:0]   rk_idx, g_round;
  logic [31:0]  g_input;

  key_expansion_ctrl dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .start      (start),
    .key_in     (key_in),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_idx     (rk_idx),
    .g_enable   (g_enable),
    .g_input    (g_input),
    .g_round    (g_round),
    .g_output   (g_output),
    .g_done     (g_done),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 tb_clk = ~tb_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- behavioural AES-128 key schedule ----
  logic [7:0]   sb [256];
  logic [127:0] exp_keys [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] g_ref(input logic [31:0] w, input int r);
    logic [31:0] rot = {w[23:0], w[31:24]};
    logic [7:0]  rc  = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return {sb[rot[31:24]] ^ rc, sb[rot[23:16]], sb[rot[15:8]], sb[rot[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = g_ref(t, i / 4);
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---- G block model: answers g_enable after g_lat cycles ----
  int          g_lat = 2;
  int          g_cnt = 0;
  logic [31:0] g_res = '0;

  initial forever begin
    @(negedge tb_clk);
    g_done   = 1'b0;
    g_output = $urandom;
    if (g_cnt > 0) begin
      g_cnt--;
      if (g_cnt == 0) begin
        g_done   = 1'b1;
        g_output = g_res;
      end
    end
    if (g_enable) begin
      g_cnt = g_lat;
      g_res = g_ref(g_input, int'(g_round));
    end
  end

  // ---- consumer ----
  int ready_mode = 0;
  int hold_cnt   = 0;

  initial forever begin
    @(posedge tb_clk);
    #1;
    if (ready_mode == 0) begin
      rk_ready = 1'b1;
    end else if (ready_mode == 1) begin
      rk_ready = ($urandom_range(0, 99) < 60);
    end else if (rk_valid && rk_idx == 4'd3 && hold_cnt < 5) begin
      rk_ready = 1'b0;
      hold_cnt++;
    end else begin
      rk_ready = 1'b1;
    end
  end

  // ---- monitor ----
  int           cyc = 0;
  int           exp_next = 0;
  int           done_cnt = 0;
  int           greq_cnt = 0;
  int           hs_cyc [11];
  logic [127:0] got_keys [11];
  logic [31:0]  first_gin = '0;
  logic [3:0]   first_grnd = '0;
  logic         hold_prev = 1'b0;
  logic [127:0] hold_data = '0;
  logic [3:0]   hold_idx = '0;

  always @(posedge tb_clk) cyc++;

  initial forever begin
    @(negedge tb_clk);
    if (n_rst) begin
      if (hold_prev) begin
        check("hold_valid", rk_valid, 1);
        check("hold_data", rk_data, hold_data);
        check("hold_idx", rk_idx, hold_idx);
      end
      check("g_en_in_out", g_enable & rk_valid, 0);
      if (rk_valid) check("busy_in_out", busy, 1);
      if (rk_valid && rk_ready) begin
        check("rk_idx", rk_idx, exp_next);
        if (rk_idx <= 4'd10) begin
          check("rk_data", rk_data, exp_keys[rk_idx]);
          got_keys[rk_idx] = rk_data;
          hs_cyc[rk_idx]   = cyc;
        end
        exp_next++;
      end
      if (g_enable) begin
        check("g_round", g_round, exp_next);
        if (exp_next >= 1 && exp_next <= 10)
          check("g_input", g_input, exp_keys[exp_next-1][31:0]);
        if (greq_cnt == 0) begin
          first_gin  = g_input;
          first_grnd = g_round;
        end
        greq_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", exp_next, 11);
      end
      hold_prev = rk_valid && !rk_ready;
      hold_data = rk_data;
      hold_idx  = rk_idx;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---- sequencing helpers ----
  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_start(input logic [127:0] k);
    @(posedge tb_clk);
    #1;
    key_in   = k;
    start    = 1'b1;
    expand(k);
    exp_next = 0;
    greq_cnt = 0;
    @(posedge tb_clk);
    #1;
    start  = 1'b0;
    key_in = rand_key();
    check("start_valid", rk_valid, 1);
    check("start_idx", rk_idx, 0);
    check("start_data", rk_data, k);
    check("start_busy", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge tb_clk);
      n++;
    end
    check("done_seen", done_cnt > d0, 1);
    repeat (3) @(posedge tb_clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_greq(input int n, input int budget);
    int c = 0;
    while (greq_cnt < n && c < budget) begin
      @(posedge tb_clk);
      c++;
    end
    check("greq_seen", greq_cnt >= n, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, rk_valid, 0);
    check({tag, "_data"}, rk_data, 0);
    check({tag, "_idx"}, rk_idx, 0);
    check({tag, "_gen"}, g_enable, 0);
    check({tag, "_gin"}, g_input, 0);
    check({tag, "_grnd"}, g_round, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] k1;
  int           d0;
  int           c;

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    repeat (3) @(posedge tb_clk);
    #1;
    check_reset_outputs("reset");
    check("reset_rd", rk_rd_data, 0);
    n_rst = 1'b1;

    // FIPS-197 vector, no back-pressure
    g_lat      = 2;
    ready_mode = 0;
    do_start(fips_key);
    wait_done(400);
    check("fips_first_gin", first_gin, 32'h09cf4f3c);
    check("fips_first_grnd", first_grnd, 1);
    check("fips_rk0", got_keys[0], fips_key);
    check("fips_rk1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_rk10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_done_total", done_cnt, 1);
    check("period", hs_cyc[2] - hs_cyc[1], g_lat + 2);
`ifdef KEY_STORE_EN
    rk_rd_idx = 4'd1;
    #1;
    check("store_rd1", rk_rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_rd_idx = 4'd10;
    #1;
    check("store_rd10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rk_rd_idx = 4'd12;
    #1;
    check("store_rd12", rk_rd_data, 0);
`else
    rk_rd_idx = 4'd1;
    #1;
    check("rd_tied0", rk_rd_data, 0);
`endif

    // Back-pressure at round key 3
    ready_mode = 2;
    hold_cnt   = 0;
    do_start(rand_key());
    wait_done(400);
    check("hold_cycles", hold_cnt, 5);
    check("hold_period", hs_cyc[3] - hs_cyc[2], g_lat + 2 + 5);

    // Random keys, G latency and consumer stalls
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      g_lat = $urandom_range(1, 5);
      do_start(rand_key());
      wait_done(1500);
    end

    // start while busy is ignored
    ready_mode = 0;
    g_lat      = 3;
    k1         = rand_key();
    do_start(k1);
    c = 0;
    while (!(rk_valid && rk_idx == 4'd2) && c < 100) begin
      @(posedge tb_clk);
      #1;
      c++;
    end
    check("busy_start_reach", rk_idx, 2);
    start  = 1'b1;
    key_in = rand_key();
    @(posedge tb_clk);
    #1;
    start = 1'b0;
    wait_done(400);
    check("busy_start_rk10", got_keys[10], exp_keys[10]);

    // abort in G_WAIT of round 4
    g_lat = 4;
    do_start(rand_key());
    wait_greq(4, 200);
    #1;
    d0    = done_cnt;
    abort = 1'b1;
    @(posedge tb_clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rk_valid, 0);
    repeat (8) @(posedge tb_clk);
    #1;
    check("abort_late_busy", busy, 0);
    check("abort_late_valid", rk_valid, 0);
    check("abort_late_idx", rk_idx, 3);
    check("abort_no_done", done_cnt, d0);
    do_start('0);
    wait_done(400);
    check("zero_rk1", got_keys[1], 128'h62636363626363636263636362636363);

    // reset mid round 6
    do_start(rand_key());
    wait_greq(6, 200);
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (6) @(posedge tb_clk);
    #1;
    check_reset_outputs("midrst_hold");
`ifdef KEY_STORE_EN
    rk_rd_idx = 4'd1;
    #1;
    check("store_cleared", rk_rd_data, 0);
`endif
    n_rst = 1'b1;
    g_lat = 2;
    do_start(rand_key());
    wait_done(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
